decode_cycle: RTL and testbench

DECODE_CYCLE -- requirements
Module: decode_cycle

---
 rtl/decode_pkg.sv | 19 +
 rtl/register_file.sv | 64 ++++++
 rtl/decode_cycle.sv | 90 +++++++++
 tb/tb_decode_cycle.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode-stage constants: register index width, file depth,
// instruction field positions and immediate width.
package decode_pkg;

  localparam int REG_IDX_W = 4;
  localparam int NUM_REGS  = 16;
  localparam int INSTR_W   = 18;

  localparam int RD_MSB    = 13;
  localparam int RD_LSB    = 10;
  localparam int RS1_MSB   = 9;
  localparam int RS1_LSB   = 6;
  localparam int RS2_MSB   = 5;
  localparam int RS2_LSB   = 2;

  localparam int IMM_W     = 10;
  localparam int IMM_MSB   = IMM_W - 1;

endpackage

// File: rtl/register_file.sv
// 16-entry register file, two combinational read ports, one write port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the readers.
module register_file
  import decode_pkg::*;
#(
  parameter int DATA_W = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [REG_IDX_W-1:0] raddr1,
  input  logic [REG_IDX_W-1:0] raddr2,
  output logic [DATA_W-1:0]    rdata1,
  output logic [DATA_W-1:0]    rdata2
);

  logic [DATA_W-1:0] regs_r [NUM_REGS];

  // Register storage: cleared asynchronously, R0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (we && (waddr != 4'd0)) begin
      regs_r[waddr] <= wdata;
    end
  end

  // Read port 1.
  always_comb begin
    rdata1 = '0;
    if (raddr1 == 4'd0) begin
      rdata1 = '0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (we && (waddr == raddr1)) begin
      rdata1 = wdata;
    end
`endif
    else begin
      rdata1 = regs_r[raddr1];
    end
  end

  // Read port 2.
  always_comb begin
    rdata2 = '0;
    if (raddr2 == 4'd0) begin
      rdata2 = '0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (we && (waddr == raddr2)) begin
      rdata2 = wdata;
    end
`endif
    else begin
      rdata2 = regs_r[raddr2];
    end
  end

endmodule

// File: rtl/decode_cycle.sv
// Decode stage: register file read plus the ID/EX pipeline register.
// Optional REGFILE_BYPASS_EN enables write-to-read forwarding in the file.
module decode_cycle
  import decode_pkg::*;
#(
  parameter int DATA_W = 18,
  parameter int PC_W   = 9,
  parameter int CTRL_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INSTR_W-1:0]   InstrD,
  input  logic [PC_W-1:0]      PCD,
  input  logic [CTRL_W-1:0]    CtrlD,
  input  logic                 StallD,
  input  logic                 FlushE,
  input  logic                 RegWriteW,
  input  logic [REG_IDX_W-1:0] RdW,
  input  logic [DATA_W-1:0]    ResultW,
  output logic [DATA_W-1:0]    RD1E,
  output logic [DATA_W-1:0]    RD2E,
  output logic [DATA_W-1:0]    ImmE,
  output logic [REG_IDX_W-1:0] Rs1E,
  output logic [REG_IDX_W-1:0] Rs2E,
  output logic [REG_IDX_W-1:0] RdE,
  output logic [PC_W-1:0]      PCE,
  output logic [CTRL_W-1:0]    CtrlE
);

  logic [REG_IDX_W-1:0] rs1_s;
  logic [REG_IDX_W-1:0] rs2_s;
  logic [REG_IDX_W-1:0] rd_s;
  logic [DATA_W-1:0]    rd1_s;
  logic [DATA_W-1:0]    rd2_s;
  logic [DATA_W-1:0]    imm_s;
  logic                 unused_instr_s;

  assign rs1_s = InstrD[RS1_MSB:RS1_LSB];
  assign rs2_s = InstrD[RS2_MSB:RS2_LSB];
  assign rd_s  = InstrD[RD_MSB:RD_LSB];
  assign imm_s = {{(DATA_W-IMM_W){InstrD[IMM_MSB]}}, InstrD[IMM_MSB:0]};
  assign unused_instr_s = ^InstrD[INSTR_W-1:RD_MSB+1];

  register_file #(
    .DATA_W(DATA_W)
  ) u_register_file (
    .clk    (clk),
    .rst    (rst),
    .we     (RegWriteW),
    .waddr  (RdW),
    .wdata  (ResultW),
    .raddr1 (rs1_s),
    .raddr2 (rs2_s),
    .rdata1 (rd1_s),
    .rdata2 (rd2_s)
  );

  // ID/EX register: flush beats stall, stall holds, otherwise capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || FlushE) begin
      RD1E  <= '0;
      RD2E  <= '0;
      ImmE  <= '0;
      Rs1E  <= '0;
      Rs2E  <= '0;
      RdE   <= '0;
      PCE   <= '0;
      CtrlE <= '0;
    end else if (!StallD) begin
      RD1E  <= rd1_s;
      RD2E  <= rd2_s;
      ImmE  <= imm_s;
      Rs1E  <= rs1_s;
      Rs2E  <= rs2_s;
      RdE   <= rd_s;
      PCE   <= PCD;
      CtrlE <= CtrlD;
    end else begin
      RD1E  <= RD1E;
      RD2E  <= RD2E;
      ImmE  <= ImmE;
      Rs1E  <= Rs1E;
      Rs2E  <= Rs2E;
      RdE   <= RdE;
      PCE   <= PCE;
      CtrlE <= CtrlE;
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// Scoreboard bench for decode_cycle: reference model predicts each ID/EX
// capture, a monitor compares one cycle later. Honours REGFILE_BYPASS_EN.
module tb_decode_cycle;

  typedef struct packed {
    logic [17:0] rd1;
    logic [17:0] rd2;
    logic [17:0] imm;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [8:0]  pc;
    logic [7:0]  ctrl;
  } e_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] InstrD;
  logic [8:0]  PCD;
  logic [7:0]  CtrlD;
  logic        StallD, FlushE, RegWriteW;
  logic [3:0]  RdW;
  logic [17:0] ResultW;
  logic [17:0] RD1E, RD2E, ImmE;
  logic [3:0]  Rs1E, Rs2E, RdE;
  logic [8:0]  PCE;
  logic [7:0]  CtrlE;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [17:0] mem [16];
  e_t          exp_prev;
  e_t          exp_q [$];

  decode_cycle #(.DATA_W(18), .PC_W(9), .CTRL_W(8)) dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .CtrlD(CtrlD),
    .StallD(StallD), .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW),
    .ResultW(ResultW), .RD1E(RD1E), .RD2E(RD2E), .ImmE(ImmE), .Rs1E(Rs1E),
    .Rs2E(Rs2E), .RdE(RdE), .PCE(PCE), .CtrlE(CtrlE)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic check_e_zero(input string tag);
    check({tag, "_rd1e"}, 32'(RD1E), 32'd0);
    check({tag, "_rd2e"}, 32'(RD2E), 32'd0);
    check({tag, "_imme"}, 32'(ImmE), 32'd0);
    check({tag, "_rs1e"}, 32'(Rs1E), 32'd0);
    check({tag, "_rs2e"}, 32'(Rs2E), 32'd0);
    check({tag, "_rde"},  32'(RdE),  32'd0);
    check({tag, "_pce"},  32'(PCE),  32'd0);
    check({tag, "_ctrle"},32'(CtrlE),32'd0);
  endtask

  function automatic logic [17:0] mk_instr(input logic [3:0] rd, input logic [3:0] rs1,
                                           input logic [3:0] rs2);
    return {4'd0, rd, rs1, rs2, 2'd0};
  endfunction

  // Architectural read as seen in the decode cycle.
  function automatic logic [17:0] model_read(input logic [3:0] idx, input logic we,
                                             input logic [3:0] wa, input logic [17:0] wd);
    if (idx == 4'd0) return 18'd0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa == idx) return wd;
`endif
    return mem[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem[i] = 18'd0;
    exp_prev = '0;
  endtask

  // Drive one decode cycle, predict the ID/EX contents after the edge.
  task automatic step(input logic [17:0] instr, input logic [8:0] pc, input logic [7:0] ctrl,
                      input logic stall, input logic flush, input logic we,
                      input logic [3:0] wa, input logic [17:0] wd);
    e_t n, e;
    InstrD = instr; PCD = pc; CtrlD = ctrl; StallD = stall; FlushE = flush;
    RegWriteW = we; RdW = wa; ResultW = wd;
    n.rs1  = instr[9:6];
    n.rs2  = instr[5:2];
    n.rd   = instr[13:10];
    n.pc   = pc;
    n.ctrl = ctrl;
    n.rd1  = model_read(n.rs1, we, wa, wd);
    n.rd2  = model_read(n.rs2, we, wa, wd);
    n.imm  = instr[9] ? 18'h3FC00 + {8'd0, instr[9:0]} : {8'd0, instr[9:0]};
    if (flush)      e = '0;
    else if (stall) e = exp_prev;
    else            e = n;
    if (we && wa != 4'd0) mem[wa] = wd;
    exp_q.push_back(e);
    exp_prev = e;
    @(posedge clk);
    #2;
  endtask

  // Monitor: one prediction per captured edge.
  always @(posedge clk) begin
    e_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_rd1e",  32'(RD1E),  32'(e.rd1));
      check("sb_rd2e",  32'(RD2E),  32'(e.rd2));
      check("sb_imme",  32'(ImmE),  32'(e.imm));
      check("sb_rs1e",  32'(Rs1E),  32'(e.rs1));
      check("sb_rs2e",  32'(Rs2E),  32'(e.rs2));
      check("sb_rde",   32'(RdE),   32'(e.rd));
      check("sb_pce",   32'(PCE),   32'(e.pc));
      check("sb_ctrle", 32'(CtrlE), 32'(e.ctrl));
    end
  end

  initial begin
    rst = 1'b1;
    InstrD = 18'd0; PCD = 9'd0; CtrlD = 8'd0; StallD = 1'b0; FlushE = 1'b0;
    RegWriteW = 1'b0; RdW = 4'd0; ResultW = 18'd0;
    model_reset();
    #3;
    check_e_zero("reset");
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Same-cycle write/read of R5.
    step(mk_instr(4'd1, 4'd5, 4'd0), 9'h011, 8'h21, 1'b0, 1'b0, 1'b1, 4'd5, 18'h00123);
`ifdef REGFILE_BYPASS_EN
    check("bypass_r5", 32'(RD1E), 32'h00123);
`else
    check("nobypass_r5", 32'(RD1E), 32'h00000);
`endif
    step(mk_instr(4'd2, 4'd5, 4'd5), 9'h012, 8'h22, 1'b0, 1'b0, 1'b0, 4'd0, 18'd0);
    check("r5_after", 32'(RD2E), 32'h00123);

    // Write R3 then read it.
    step(mk_instr(4'd0, 4'd0, 4'd0), 9'h013, 8'h23, 1'b0, 1'b0, 1'b1, 4'd3, 18'h2A5F3);
    step(mk_instr(4'd4, 4'd3, 4'd0), 9'h014, 8'h24, 1'b0, 1'b0, 1'b0, 4'd0, 18'd0);
    check("r3_rd1", 32'(RD1E), 32'h2A5F3);
    check("r3_rd2", 32'(RD2E), 32'h00000);

    // Attempted write to R0.
    step(mk_instr(4'd0, 4'd0, 4'd0), 9'h015, 8'h25, 1'b0, 1'b0, 1'b1, 4'd0, 18'h3FFFF);
    step(mk_instr(4'd0, 4'd0, 4'd3), 9'h016, 8'h26, 1'b0, 1'b0, 1'b0, 4'd0, 18'd0);
    check("r0_read", 32'(RD1E), 32'h00000);

    // Immediate sign extension.
    step(18'h003FF, 9'h017, 8'h27, 1'b0, 1'b0, 1'b0, 4'd0, 18'd0);
    check("imm_neg", 32'(ImmE), 32'h3FFFF);
    step(18'h001FF, 9'h018, 8'h28, 1'b0, 1'b0, 1'b0, 4'd0, 18'd0);
    check("imm_pos", 32'(ImmE), 32'h001FF);

    // Stall two cycles with changing instruction (write still lands), then stall+flush.
    step(mk_instr(4'd6, 4'd3, 4'd5), 9'h0A0, 8'h5A, 1'b0, 1'b0, 1'b0, 4'd0, 18'd0);
    step(mk_instr(4'd7, 4'd1, 4'd2), 9'h0A1, 8'h5B, 1'b1, 1'b0, 1'b1, 4'd9, 18'h0BEEF);
    step(mk_instr(4'd8, 4'd9, 4'd9), 9'h0A2, 8'h5C, 1'b1, 1'b0, 1'b0, 4'd0, 18'd0);
    check("stall_pc", 32'(PCE), 32'h0A0);
    step(mk_instr(4'd8, 4'd9, 4'd9), 9'h0A3, 8'h5D, 1'b1, 1'b1, 1'b0, 4'd0, 18'd0);
    check_e_zero("flush");
    step(mk_instr(4'd8, 4'd9, 4'd9), 9'h0A4, 8'h5E, 1'b0, 1'b0, 1'b0, 4'd0, 18'd0);
    check("stall_write", 32'(RD1E), 32'h0BEEF);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step(18'($urandom), 9'($urandom), 8'($urandom),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
           1'($urandom), 4'($urandom), 18'($urandom));
    end

    // Asynchronous reset between edges after loading R7.
    step(mk_instr(4'd0, 4'd0, 4'd0), 9'h031, 8'h31, 1'b0, 1'b0, 1'b1, 4'd7, 18'h15A5A);
    step(mk_instr(4'd2, 4'd7, 4'd7), 9'h055, 8'hC3, 1'b0, 1'b0, 1'b0, 4'd0, 18'd0);
    check("r7_loaded", 32'(RD1E), 32'h15A5A);
    #3;
    rst = 1'b1;
    #1;
    check_e_zero("rst_async");
    RegWriteW = 1'b1; RdW = 4'd7; ResultW = 18'h3FFFF;
    @(posedge clk);
    #2;
    check_e_zero("rst_held");
    rst = 1'b0;
    RegWriteW = 1'b0;
    model_reset();
    step(mk_instr(4'd1, 4'd7, 4'd7), 9'h056, 8'hC4, 1'b0, 1'b0, 1'b0, 4'd0, 18'd0);
    check("r7_cleared", 32'(RD1E), 32'h00000);
    check("first_capture_pc", 32'(PCE), 32'h056);

    @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
